optmult_dot_accum: RTL and testbench
====================================

// Module: optmult_dot_accum
// PURPOSE
//   Registered dot-product accumulator directly downstream of the LUT6_2/carry-chain
//   multiplier. Takes its raw M_W+N_W product each cycle under a valid/ready handshake.
//   Sums up to LEN products per frame and presents the frame sum on an output handshake.
//   Provides the first clocked stage after the unclocked multiplier and closes timing on it.
// PARAMETERS
//   UNSIGNED  1   1: products are unsigned, zero-extend; 0: two's complement, sign-extend
//   M_W       8   multiplicand width of the upstream multiplier
//   N_W       8   multiplier width of the upstream multiplier
//   LEN       16  max products per frame (>=1)
//   CNT_W     $clog2(LEN+1)  localparam, beat-counter width
//   ACC_W     M_W+N_W+$clog2(LEN)  localparam, accumulator width
// PORTS
//   clk        in   1            rising-edge clock
//   rst        in   1            synchronous reset, active-high
//   in_valid   in   1            in_prod/in_last valid this cycle
//   in_ready   out  1            block accepts a beat this cycle
//   in_prod    in   M_W+N_W      product from the multiplier
//   in_last    in   1            accepted beat closes the frame
//   out_valid  out  1            out_sum/out_count valid
//   out_ready  in   1            consumer takes the result
//   out_sum    out  ACC_W        frame sum
//   out_count  out  CNT_W        number of beats in the frame (1..LEN)
// BEHAVIOUR
//   - Reset (sync, checked first, overrides everything): state=ACCUM, acc=0, cnt=0.
//     Outputs: in_ready=1, out_valid=0, out_sum=0, out_count=0.
//   - Beat accept: acc = in_valid & in_ready.
//   - Extension: in_prod is extended to ACC_W, zero-extended if UNSIGNED=1, else sign-extended.
//   - Accumulator: ACC_W is sized so LEN worst-case products never overflow.
//     Addition wraps mod 2^ACC_W (no saturation).
//   - FSM, 2 states:
//     ACCUM: in_ready=1, out_valid=0.
//       On acc: acc<=acc+ext(in_prod), cnt<=cnt+1.
//       If in_last or cnt+1==LEN: out_sum<=acc+ext(in_prod), out_count<=cnt+1,
//       acc<=0, cnt<=0, ->HOLD.
//       in_valid without acc is not possible; in_valid=0 leaves state unchanged.
//     HOLD: in_ready=0, out_valid=1.
//       out_sum/out_count are held stable until out_valid&out_ready, then ->ACCUM next cycle.
//       No beat is accepted in the handshake cycle.
//   - Latency: result is valid the cycle after the closing beat is accepted.
//   - Throughput: at most one frame per (frame_len+1) cycles, plus consumer stall.
//   - Forced close: frame closes at LEN beats even without in_last.
//     The next beat starts a new frame; an in_last arriving later closes that frame.
//   - in_last on the first beat gives a single-beat frame (out_count=1).
//   - out_sum/out_count keep their last value after handshake (don't-care while out_valid=0).
//   - Reset mid-frame or in HOLD discards the partial/pending result; no output is emitted.
//   - in_prod/in_last are ignored when in_ready=0 (upstream holds them per handshake rules).
// TESTING
//   T1 unsigned, M_W=N_W=8, LEN=4: beats 255*255=65025 x4, no in_last
//      -> out_sum=260100, out_count=4, out_valid 1 cycle after 4th beat.
//   T2 UNSIGNED=0: products -128*127=-16256 and 3*-5=-15, in_last on 2nd beat
//      -> out_sum=-16271 (two's complement, ACC_W bits), out_count=2.
//   T3 single beat 7 with in_last on the first beat -> out_sum=7, out_count=1.
//      Next frame starts from acc=0.
//   T4 hold out_ready=0 for 5 cycles with in_valid=1
//      -> in_ready=0, out_sum stable for all 5 cycles.
//      After out_ready=1 (one cycle): in_ready=1 the next cycle.
//   T5 assert rst after 2 of 4 beats, then send beats 1,2,3,4 with in_last on the 4th
//      -> out_sum=10, out_count=4; no result from the aborted frame.
//   T6 random back-to-back frames vs a scoreboard using a behavioural a*b model
//      -> every out_sum/out_count matches, no beat lost or duplicated.

Source files
------------

// File: rtl/optmult_dot_accum_if.sv
// Handshake bundle between the multiplier, the dot-product accumulator and the result consumer.
// master drives beats in and takes results out; slave is the accumulator.
interface optmult_dot_accum_if #(
  parameter int M_W = 8,
  parameter int N_W = 8,
  parameter int LEN = 16
);
  localparam int P_W   = M_W + N_W;
  localparam int CNT_W = $clog2(LEN + 1);
  localparam int ACC_W = M_W + N_W + $clog2(LEN);

  logic             in_valid;
  logic             in_ready;
  logic [P_W-1:0]   in_prod;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count
  );

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count
  );
endinterface

// File: rtl/optmult_dot_accum.sv
// Frame accumulator for raw multiplier products; result valid 1 cycle after the closing beat.
// Backpressure: in_ready drops while a result is held; result held until out_ready, no beat taken then.
module optmult_dot_accum #(
  parameter int UNSIGNED = 1,
  parameter int M_W      = 8,
  parameter int N_W      = 8,
  parameter int LEN      = 16
) (
  input logic               clk,
  input logic               rst,
  optmult_dot_accum_if.slave bus
);
  localparam int P_W   = M_W + N_W;
  localparam int CNT_W = $clog2(LEN + 1);
  localparam int ACC_W = M_W + N_W + $clog2(LEN);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;

  // Size cast of a signed operand sign-extends; of an unsigned one zero-extends.
  always_comb begin
    if (UNSIGNED != 0) prod_ext = ACC_W'(bus.in_prod);
    else               prod_ext = ACC_W'($signed(bus.in_prod));
  end

  assign acc_next = acc_q + prod_ext;
  assign cnt_next = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    sum_d         = sum_q;
    count_d       = count_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_q)
      ACCUM: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          // A frame closes on in_last or when it reaches LEN beats.
          if (bus.in_last || (cnt_next == CNT_W'(LEN))) begin
            sum_d   = acc_next;
            count_d = cnt_next;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            acc_d = acc_next;
            cnt_d = cnt_next;
          end
        end
      end
      HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  assign bus.out_sum   = sum_q;
  assign bus.out_count = count_q;
endmodule

// File: tb/tb_optmult_dot_accum.sv
// Drives an unsigned and a signed accumulator with identical handshakes; a monitor
// checks every emitted frame against sums of a*b computed by the bench.
module tb_optmult_dot_accum;
  localparam int M_W   = 8;
  localparam int N_W   = 8;
  localparam int LEN   = 4;
  localparam int CNT_W = $clog2(LEN + 1);
  localparam int ACC_W = M_W + N_W + $clog2(LEN);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid, in_last, ordy, rnd_on;
  logic [7:0] opa, opb;
  logic signed [15:0] sa, sb;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_u[$];
  int exp_s[$];
  int exp_c[$];
  int m_u, m_s, m_n;

  optmult_dot_accum_if #(.M_W(M_W), .N_W(N_W), .LEN(LEN)) ubus ();
  optmult_dot_accum_if #(.M_W(M_W), .N_W(N_W), .LEN(LEN)) sbus ();

  optmult_dot_accum #(.UNSIGNED(1), .M_W(M_W), .N_W(N_W), .LEN(LEN)) u_dut (
    .clk(clk), .rst(rst), .bus(ubus)
  );
  optmult_dot_accum #(.UNSIGNED(0), .M_W(M_W), .N_W(N_W), .LEN(LEN)) s_dut (
    .clk(clk), .rst(rst), .bus(sbus)
  );

  assign sa = {{8{opa[7]}}, opa};
  assign sb = {{8{opb[7]}}, opb};
  assign ubus.in_valid  = in_valid;
  assign ubus.in_last   = in_last;
  assign ubus.out_ready = ordy;
  assign ubus.in_prod   = {8'b0, opa} * {8'b0, opb};
  assign sbus.in_valid  = in_valid;
  assign sbus.in_last   = in_last;
  assign sbus.out_ready = ordy;
  assign sbus.in_prod   = sa * sb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Reference: a frame is the running sum of a*b, closed by last or by its LEN-th beat.
  task automatic model_accept(input logic [7:0] a, input logic [7:0] b, input logic last);
    m_u += int'(a) * int'(b);
    m_s += int'(signed'(a)) * int'(signed'(b));
    m_n++;
    if (last || m_n == LEN) begin
      exp_u.push_back(m_u);
      exp_s.push_back(m_s);
      exp_c.push_back(m_n);
      m_u = 0; m_s = 0; m_n = 0;
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    int n = 0;
    in_valid = 1'b1; opa = a; opb = b; in_last = last;
    while (!ubus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ubus.in_ready) begin
      chk("send_timeout", 32'(ubus.in_ready), 32'd1);
    end else begin
      model_accept(a, b, last);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Monitor: inputs only change on negedge, so values seen here are what the next posedge sees.
  initial begin
    int eu, es, ec;
    logic [ACC_W-1:0] mu, ms;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && ubus.out_valid && ordy) begin
        chk("s_out_valid", 32'(sbus.out_valid), 32'd1);
        if (exp_c.size() == 0) begin
          chk("unexpected_result", 32'(exp_c.size()), 32'd1);
        end else begin
          eu = exp_u.pop_front();
          es = exp_s.pop_front();
          ec = exp_c.pop_front();
          mu = eu[ACC_W-1:0];
          ms = es[ACC_W-1:0];
          chk("u_sum", 32'(ubus.out_sum), 32'(mu));
          chk("u_count", 32'(ubus.out_count), 32'(ec));
          chk("s_sum", 32'(sbus.out_sum), 32'(ms));
          chk("s_count", 32'(sbus.out_count), 32'(ec));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [ACC_W-1:0] e;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; ordy = 1'b1; rnd_on = 1'b0;
    opa = '0; opb = '0;
    m_u = 0; m_s = 0; m_n = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(ubus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(ubus.out_valid), 32'd0);
    chk("rst_out_sum", 32'(ubus.out_sum), 32'd0);
    chk("rst_out_count", 32'(ubus.out_count), 32'd0);
    chk("rst_s_out_valid", 32'(sbus.out_valid), 32'd0);

    // T1: forced close at LEN beats without in_last
    repeat (3) send(8'd255, 8'd255, 1'b0);
    chk("t1_not_early", 32'(ubus.out_valid), 32'd0);
    send(8'd255, 8'd255, 1'b0);
    chk("t1_latency", 32'(ubus.out_valid), 32'd1);
    chk("t1_sum", 32'(ubus.out_sum), 32'd260100);
    chk("t1_count", 32'(ubus.out_count), 32'd4);

    // T2: signed products, in_last on second beat
    send(8'h80, 8'h7f, 1'b0);
    send(8'd3, 8'hfb, 1'b1);
    e = ACC_W'(-16271);
    chk("t2_ssum", 32'(sbus.out_sum), 32'(e));
    chk("t2_scount", 32'(sbus.out_count), 32'd2);

    // T3: single-beat frame, then a fresh frame from zero
    send(8'd7, 8'd1, 1'b1);
    chk("t3_sum", 32'(ubus.out_sum), 32'd7);
    chk("t3_count", 32'(ubus.out_count), 32'd1);
    send(8'd2, 8'd3, 1'b1);
    chk("t3_next_sum", 32'(ubus.out_sum), 32'd6);
    chk("t3_next_count", 32'(ubus.out_count), 32'd1);

    // T4: consumer stall holds the result and blocks input
    @(negedge clk);
    ordy = 1'b0;
    send(8'd10, 8'd10, 1'b0);
    send(8'd1, 8'd1, 1'b1);
    in_valid = 1'b1; opa = 8'd9; opb = 8'd9; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_in_ready_low", 32'(ubus.in_ready), 32'd0);
      chk("t4_sum_stable", 32'(ubus.out_sum), 32'd101);
      @(negedge clk);
    end
    ordy = 1'b1;
    @(negedge clk);
    chk("t4_in_ready_back", 32'(ubus.in_ready), 32'd1);
    chk("t4_out_valid_drop", 32'(ubus.out_valid), 32'd0);
    in_valid = 1'b0;

    // T5: reset mid-frame discards the partial sum
    send(8'd50, 8'd1, 1'b0);
    send(8'd60, 8'd1, 1'b0);
    rst = 1'b1;
    m_u = 0; m_s = 0; m_n = 0;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_out_valid", 32'(ubus.out_valid), 32'd0);
    chk("t5_rst_in_ready", 32'(ubus.in_ready), 32'd1);
    send(8'd1, 8'd1, 1'b0);
    send(8'd2, 8'd1, 1'b0);
    send(8'd3, 8'd1, 1'b0);
    send(8'd4, 8'd1, 1'b1);
    chk("t5_sum", 32'(ubus.out_sum), 32'd10);
    chk("t5_count", 32'(ubus.out_count), 32'd4);

    // T6: random frames with random consumer stalls
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(negedge clk);
          if (rnd_on) ordy = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 300; i++)
      send(8'($urandom), 8'($urandom), $urandom_range(0, 4) == 0);
    rnd_on = 1'b0;
    repeat (2) @(negedge clk);
    ordy = 1'b1;
    send(8'($urandom), 8'($urandom), 1'b1);
    n = 0;
    while (exp_c.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("drain_empty", 32'(exp_c.size()), 32'd0);
    chk("end_out_valid", 32'(ubus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
